// File: rtl/key_expansion_seq.sv
// Iterative AES-128 key schedule, one round key per clock; optional round-key stream under KEYEXP_RK_STREAM_EN.
// Latency 10 clocks from accepted start to w_valid; start is ignored while busy, no other backpressure.
module key_expansion_seq #(
    parameter int unsigned NR = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [127:0]    key_in,
    output logic            busy,
    output logic            w_valid,
    output logic [1407:0]   w
`ifdef KEYEXP_RK_STREAM_EN
    ,
    output logic [127:0]    rk_out,
    output logic            rk_valid,
    output logic [3:0]      rk_idx
`endif
);

    localparam int          NR_I       = int'(NR);
    localparam logic [3:0]  LAST_ROUND = 4'(NR);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXPAND,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_busy;
    logic            r_w_valid;
    logic [1407:0]   r_w;
    logic [127:0]    r_rk;
    logic [3:0]      r_round;
    logic [7:0]      r_rcon;

    logic            w_accept;
    logic            w_step;
    logic            w_last;
    logic [31:0]     w_t;
    logic [31:0]     w_q0;
    logic [31:0]     w_q1;
    logic [31:0]     w_q2;
    logic [31:0]     w_q3;
    logic [127:0]    w_rk_nxt;

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [10:0] base;
        base = 11'd2047 - {a, 3'b000};
        return SBOX[base -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_EXPAND;
                end
            end
            S_EXPAND: begin
                w_step = 1'b1;
                if (r_round == LAST_ROUND) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The previous round key is kept in r_rk so the next one never needs a wide read-back mux on w.
    always_comb begin
        w_t      = sub_word({r_rk[23:0], r_rk[31:24]}) ^ {r_rcon, 24'h000000};
        w_q0     = r_rk[127:96] ^ w_t;
        w_q1     = r_rk[95:64]  ^ w_q0;
        w_q2     = r_rk[63:32]  ^ w_q1;
        w_q3     = r_rk[31:0]   ^ w_q2;
        w_rk_nxt = {w_q0, w_q1, w_q2, w_q3};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_w       <= '0;
            r_rk      <= '0;
            r_round   <= 4'd0;
            r_rcon    <= 8'h01;
            r_busy    <= 1'b0;
            r_w_valid <= 1'b0;
        end else if (w_accept) begin
            r_w       <= {key_in, 1280'b0};
            r_rk      <= key_in;
            r_round   <= 4'd1;
            r_rcon    <= 8'h01;
            r_busy    <= 1'b1;
            r_w_valid <= 1'b0;
        end else if (w_step) begin
            for (int i = 1; i <= NR_I; i++) begin
                if (r_round == 4'(i)) begin
                    r_w[1407-128*i -: 128] <= w_rk_nxt;
                end
            end
            r_rk    <= w_rk_nxt;
            r_round <= r_round + 4'd1;
            r_rcon  <= xtime(r_rcon);
            if (w_last) begin
                r_busy    <= 1'b0;
                r_w_valid <= 1'b1;
            end
        end
    end

    assign busy    = r_busy;
    assign w_valid = r_w_valid;
    assign w       = r_w;

`ifdef KEYEXP_RK_STREAM_EN
    logic        r_rk_valid;
    logic [3:0]  r_rk_idx;

    // r_rk is exactly the slice written on the previous edge, so it doubles as the stream data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rk_valid <= 1'b0;
            r_rk_idx   <= 4'd0;
        end else if (w_accept) begin
            r_rk_valid <= 1'b1;
            r_rk_idx   <= 4'd0;
        end else if (w_step) begin
            r_rk_valid <= 1'b1;
            r_rk_idx   <= r_round;
        end else begin
            r_rk_valid <= 1'b0;
        end
    end

    assign rk_out   = r_rk;
    assign rk_valid = r_rk_valid;
    assign rk_idx   = r_rk_idx;
`endif

endmodule

// File: tb/tb_key_expansion_seq.sv
// Scoreboard bench for key_expansion_seq using the FIPS-197 and all-zero key schedules.
module tb_key_expansion_seq;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_KEY  = 128'h0;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [127:0]    key_in;
    logic            busy;
    logic            w_valid;
    logic [1407:0]   w;
`ifdef KEYEXP_RK_STREAM_EN
    logic [127:0]    rk_out;
    logic            rk_valid;
    logic [3:0]      rk_idx;
`endif

    always #5 clk = ~clk;

    key_expansion_seq #(.NR(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .key_in  (key_in),
        .busy    (busy),
        .w_valid (w_valid),
        .w       (w)
`ifdef KEYEXP_RK_STREAM_EN
        ,
        .rk_out  (rk_out),
        .rk_valid(rk_valid),
        .rk_idx  (rk_idx)
`endif
    );

    typedef struct {
        logic [127:0] rk0;
        logic [127:0] rk1;
        logic [127:0] rk10;
        int           cyc;
    } exp_t;

    exp_t          sb_q[$];
    logic [127:0]  rk_q[$];
    exp_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic          prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: each rising edge of w_valid consumes one scoreboard entry.
    always @(negedge clk) begin
        if (w_valid === 1'b1 && prev_valid !== 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_w_valid: got w_valid=1 expected no pending expansion (cycle %0d)", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("valid_latency", 128'(cyc), 128'(mon_e.cyc));
                chk("round_key_0", w[1407:1280], mon_e.rk0);
                chk("round_key_1", w[1279:1152], mon_e.rk1);
                chk("round_key_10", w[127:0], mon_e.rk10);
            end
        end
        prev_valid = w_valid;
    end

`ifdef KEYEXP_RK_STREAM_EN
    int rk_next = 0;
    always @(negedge clk) begin
        if (rk_valid === 1'b1) begin
            chk("rk_idx_order", 128'(rk_idx), 128'(rk_next));
            if (rk_idx == 4'd10) begin
                if (rk_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rk_stream_unexpected: got idx 10 expected no pending expansion");
                end else begin
                    chk("rk_out_idx10", rk_out, rk_q.pop_front());
                end
                rk_next = 0;
            end else begin
                rk_next = rk_next + 1;
            end
        end else if (busy === 1'b0) begin
            rk_next = 0;
        end
    end
`endif

    task automatic kick(input logic [127:0] k, input logic [127:0] rk1, input logic [127:0] rk10,
                        input bit push);
        @(negedge clk);
        start  = 1'b1;
        key_in = k;
        if (push) begin
            sb_q.push_back('{k, rk1, rk10, cyc + 11});
            rk_q.push_back(rk10);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb_q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL wait_done_timeout: got %0d pending expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset  = 1'b1;
        start  = 1'b0;
        key_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {127'b0, busy}, 128'd0);
        chk("reset_w_valid", {127'b0, w_valid}, 128'd0);
        chk("reset_w_zero", {127'b0, |w}, 128'd0);
        reset = 1'b0;

        kick(FIPS_KEY, FIPS_RK1, FIPS_RK10, 1'b1);
        wait_done();

        kick(ZERO_KEY, ZERO_RK1, ZERO_RK10, 1'b1);
        wait_done();

        // Second start and key change mid-expansion must be ignored.
        kick(FIPS_KEY, FIPS_RK1, FIPS_RK10, 1'b1);
        chk("busy_hold_1", {127'b0, busy}, 128'd1);
        for (int i = 2; i <= 10; i++) begin
            @(negedge clk);
            if (i == 4) begin
                start  = 1'b1;
                key_in = ZERO_KEY;
            end else if (i == 5) begin
                start = 1'b0;
            end
            chk($sformatf("busy_hold_%0d", i), {127'b0, busy}, 128'd1);
        end
        wait_done();

        // Reset aborts an expansion in flight.
        kick(FIPS_KEY, FIPS_RK1, FIPS_RK10, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", {127'b0, busy}, 128'd0);
        chk("abort_w_valid", {127'b0, w_valid}, 128'd0);
        chk("abort_w_zero", {127'b0, |w}, 128'd0);
        reset = 1'b0;

        // Back-to-back: start held in the cycle w_valid first rises.
        kick(FIPS_KEY, FIPS_RK1, FIPS_RK10, 1'b1);
        n = 0;
        while (w_valid !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (w_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL b2b_wait: got w_valid=%b expected 1", w_valid);
        end
        start  = 1'b1;
        key_in = ZERO_KEY;
        sb_q.push_back('{ZERO_KEY, ZERO_RK1, ZERO_RK10, cyc + 11});
        rk_q.push_back(ZERO_RK10);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_valid_drop", {127'b0, w_valid}, 128'd0);
        wait_done();

        // Schedule is held in DONE.
        repeat (5) @(negedge clk);
        chk("done_hold_valid", {127'b0, w_valid}, 128'd1);
        chk("done_hold_rk10", w[127:0], ZERO_RK10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_expansion_seq.md
Name: key_expansion_seq

Overview:
- Iterative AES-128 key schedule; sits directly upstream of the cipher datapath.
- Expands a 128-bit cipher key into the 1408-bit expanded key bus (11 round keys) that the cipher consumes.
- Computes one full round key (4 words) per clock, then holds the bus stable with a valid flag.
- Replaces the combinational expansion, which is too deep for timing closure.

Parameters:
- NR, 10, number of rounds; fixed for AES-128, and any other value is unsupported.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to expand the key on key_in.
- key_in  input  128  cipher key, byte 0 at [127:120]; sampled only in the cycle start is accepted.
- busy  output  1  high while expansion is in progress.
- w_valid  output  1  high when w holds a complete schedule for the last accepted key.
- w  output  1408  expanded key: w[1407:1280] = round key 0 (= key), w[127:0] = round key 10; round key r at w[1407-128*r -: 128].

Behaviour:
- States:
  - IDLE: no schedule valid.
  - EXPAND: computing.
  - DONE: schedule valid.
- Reset (reset=1 at posedge):
  - state=IDLE, busy=0, w_valid=0, w=0, round counter=0, rcon=8'h01.
  - Reset mid-EXPAND aborts; w is cleared.
- start is accepted in IDLE or DONE only. On acceptance at edge E0:
  - w[1407:1280] <= key_in; all other slices <= 0.
  - round counter <= 1, rcon <= 8'h01.
  - busy <= 1, w_valid <= 0, state <= EXPAND.
- start is ignored while busy (EXPAND); key_in changes during EXPAND have no effect.
- EXPAND, edge Er for r = 1..10: round key r is written from round key r-1 (words p0..p3):
  - t = SubWord(RotWord(p3)) XOR {rcon,24'h0}.
  - q0 = p0^t, q1 = p1^q0, q2 = p2^q1, q3 = p3^q2.
  - rcon <= xtime(rcon), giving the sequence 01,02,04,08,10,20,40,80,1b,36. xtime reduction is by 8'h1b when bit 7 is set.
- RotWord rotates bytes left: {b1,b2,b3,b0}. SubWord applies the AES S-box to each of the 4 bytes; the S-box is the same one used by SubBytes.
- At E10 (round counter == NR):
  - state <= DONE, busy <= 0, w_valid <= 1.
  - Latency is exactly 10 clocks from the accepting edge to w_valid high; w_valid is visible in the cycle after E10.
- DONE: w and w_valid are held indefinitely until a new start or reset.
  - start in DONE restarts per the acceptance rule; w_valid drops after the accepting edge.
- Simultaneous reset and start: reset wins.
- Partially written slices are never flagged valid. Consumers must gate on w_valid.
- Back-to-back: start asserted in the same cycle w_valid first goes high is accepted, because the state is already DONE.

Optional Feature:
- Macro: KEYEXP_RK_STREAM_EN.
- When defined, adds three outputs:
  - rk_out [127:0]: round key just written.
  - rk_valid [0:0]: one-cycle pulse in the cycle following each write, i.e. 11 pulses per expansion, including round key 0 after E0.
  - rk_idx [3:0]: round index 0..10.
  - All three reset to 0.
  - Lets a pipelined cipher start round 0 before expansion completes.
- When undefined: no extra ports and no extra logic. w/busy/w_valid behaviour is identical in both builds.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse:
  - w_valid rises exactly 10 clocks later.
  - w[1279:1152] = a0fafe1788542cb123a339392a6c7605.
  - w[127:0] = d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key:
  - w[1279:1152] = 62636363626363636263636362636363.
  - w[127:0] = b4ef5bcb3e92e21123e951cf6f8f188e.
- Second start pulse and key_in change at cycle 4 of EXPAND:
  - Both ignored.
  - Result equals the first key's schedule; busy stays high through 10 cycles.
- Reset asserted at cycle 5 of EXPAND:
  - Next cycle w=0, busy=0, w_valid=0.
  - A subsequent start with the FIPS key yields the correct schedule.
- start held high in the cycle w_valid rises, with the zero key on key_in:
  - w_valid drops for 10 cycles, then the zero-key schedule appears.
- With KEYEXP_RK_STREAM_EN, FIPS key:
  - 11 rk_valid pulses, rk_idx 0..10.
  - rk_out at idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
